// File: rtl/rfm_pkg.sv
// Shared definitions for the RFM controller slice (rfm_unit_bank and rfm_act_issuer).
// Holds the ACT/RFM issuer state encoding and the default timing/size constants.
package rfm_pkg;

  // Default row address width
  localparam int ADDR_SIZE = 18;
  // Default activations per RFM
  localparam int RFM_TH    = 20;
  // Default minimum spacing between ACT pulses, in cycles
  localparam int T_RC      = 60;
  // Default bank blackout after an RFM, in cycles
  localparam int T_RFM     = 200;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_GAP      = 2'd1,
    S_RFM_BUSY = 2'd2
  } rfm_iss_state_t;

endpackage

// File: rtl/rfm_victim_seq.sv
// Victim-row sequencer: holds one NRR aggressor row and emits its two neighbours
// (lower first, then upper) over a valid/ready handshake. Rows at the ends of the
// address space emit only their single in-range neighbour. An NRR arriving while
// the entry is still occupied is dropped and recorded in the sticky nrr_ovf flag.
module rfm_victim_seq #(
  parameter int ADDR_SIZE = rfm_pkg::ADDR_SIZE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 nrr_cmd,
  input  logic [ADDR_SIZE-1:0] nrr_addr,
  output logic                 vic_valid,
  output logic [ADDR_SIZE-1:0] vic_addr,
  input  logic                 vic_ready,
  output logic                 nrr_ovf
);
  import rfm_pkg::*;

  logic [ADDR_SIZE-1:0] base_q;
  logic                 last_q;
  logic                 vic_hs;
  logic                 entry_free;
  logic                 nrr_take;
  logic                 nrr_drop;

  // Row 0 has no lower neighbour: it is the first victim only for nonzero rows.
  function automatic logic has_lower(input logic [ADDR_SIZE-1:0] row);
    return (row != '0);
  endfunction

  // All-ones row has no upper neighbour.
  function automatic logic has_upper(input logic [ADDR_SIZE-1:0] row);
    return !(&row);
  endfunction

  assign vic_hs     = vic_valid && vic_ready;
  // The entry frees in the same cycle its final victim is handed off.
  assign entry_free = !vic_valid || (vic_hs && last_q);
  assign nrr_take   = nrr_cmd && entry_free;
  assign nrr_drop   = nrr_cmd && !entry_free;

  // Entry capture, neighbour stepping and overflow tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vic_valid <= 1'b0;
      vic_addr  <= '0;
      base_q    <= '0;
      last_q    <= 1'b0;
      nrr_ovf   <= 1'b0;
    end else begin
      if (nrr_take) begin
        base_q    <= nrr_addr;
        vic_valid <= 1'b1;
        if (has_lower(nrr_addr)) begin
          vic_addr <= nrr_addr - 1'b1;
          last_q   <= !has_upper(nrr_addr);
        end else begin
          vic_addr <= nrr_addr + 1'b1;
          last_q   <= 1'b1;
        end
      end else if (vic_hs) begin
        if (last_q) begin
          vic_valid <= 1'b0;
        end else begin
          vic_addr <= base_q + 1'b1;
          last_q   <= 1'b1;
        end
      end
      if (nrr_drop) begin
        nrr_ovf <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/rfm_act_issuer.sv
// ACT/RFM issuer for one rfm_unit_bank: spaces ACTs by T_RC, counts rolling
// activations and inserts an RFM (with a T_RFM blackout) every RFM_TH ACTs.
// Optional victim sequencer enabled by macro RFM_ACT_ISSUER_VICTIM_EN; without
// it the victim outputs and nrr_ovf are tied to zero.
module rfm_act_issuer #(
  parameter int ADDR_SIZE = rfm_pkg::ADDR_SIZE,
  parameter int RFM_TH    = rfm_pkg::RFM_TH,
  parameter int T_RC      = rfm_pkg::T_RC,
  parameter int T_RFM     = rfm_pkg::T_RFM
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  input  logic [ADDR_SIZE-1:0]          req_addr,
  output logic                          req_ready,
  output logic                          act_cmd,
  output logic [ADDR_SIZE-1:0]          act_addr,
  output logic                          rfm_cmd,
  input  logic                          nrr_cmd,
  input  logic [ADDR_SIZE-1:0]          nrr_addr,
  output logic                          vic_valid,
  output logic [ADDR_SIZE-1:0]          vic_addr,
  input  logic                          vic_ready,
  output logic [$clog2(RFM_TH+1)-1:0]   raa_cnt,
  output logic                          nrr_ovf
);
  import rfm_pkg::*;

  localparam int RAA_W   = $clog2(RFM_TH + 1);
  localparam int CNT_MAX = (T_RC > T_RFM) ? T_RC : T_RFM;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [RAA_W-1:0] RAA_TH    = RAA_W'(RFM_TH);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(T_RC - 1);
  localparam logic [CNT_W-1:0] BUSY_LOAD = CNT_W'(T_RFM - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  rfm_iss_state_t       state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [RAA_W-1:0]     raa_d;
  logic                 act_cmd_d;
  logic [ADDR_SIZE-1:0] act_addr_d;
  logic                 rfm_cmd_d;

  assign req_ready = (state_q == S_IDLE) && (raa_cnt < RAA_TH);

  // State, counters and command outputs; reset discards any pending RFM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      raa_cnt  <= '0;
      act_cmd  <= 1'b0;
      act_addr <= '0;
      rfm_cmd  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      raa_cnt  <= raa_d;
      act_cmd  <= act_cmd_d;
      act_addr <= act_addr_d;
      rfm_cmd  <= rfm_cmd_d;
    end
  end

  // Next-state and command generation. The gap ends as the counter reaches 0 so
  // the next accept lands exactly T_RC cycles after the previous one; the
  // blackout ends on the cycle the counter reads 0, giving T_RFM cycles after
  // the rfm_cmd pulse.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    raa_d      = raa_cnt;
    act_cmd_d  = 1'b0;
    act_addr_d = act_addr;
    rfm_cmd_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          act_cmd_d  = 1'b1;
          act_addr_d = req_addr;
          raa_d      = raa_cnt + 1'b1;
          cnt_d      = GAP_LOAD;
          state_d    = S_GAP;
        end
      end
      S_GAP: begin
        if (cnt_q <= CNT_ONE) begin
          if (raa_cnt == RAA_TH) begin
            rfm_cmd_d = 1'b1;
            raa_d     = '0;
            cnt_d     = BUSY_LOAD;
            state_d   = S_RFM_BUSY;
          end else begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RFM_BUSY: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef RFM_ACT_ISSUER_VICTIM_EN
  rfm_victim_seq #(
    .ADDR_SIZE (ADDR_SIZE)
  ) u_victim_seq (
    .clk       (clk),
    .rst       (rst),
    .nrr_cmd   (nrr_cmd),
    .nrr_addr  (nrr_addr),
    .vic_valid (vic_valid),
    .vic_addr  (vic_addr),
    .vic_ready (vic_ready),
    .nrr_ovf   (nrr_ovf)
  );
`else
  logic unused_victim_in;
  assign unused_victim_in = ^{nrr_cmd, nrr_addr, vic_ready};
  assign vic_valid = 1'b0;
  assign vic_addr  = '0;
  assign nrr_ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_rfm_act_issuer.sv
// Scoreboard bench for rfm_act_issuer with default parameters. Stimulus pushes
// expected ACT, RFM and victim events; a monitor pops them as the DUT emits.
module tb_rfm_act_issuer;
  localparam int AW = 18;

  typedef struct {
    int             cyc;
    logic [AW-1:0]  addr;
    int             raa;
  } act_exp_t;

  typedef struct {
    int             cyc;
    logic [AW-1:0]  addr;
  } vic_exp_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           req_valid = 1'b0;
  logic [AW-1:0]  req_addr = '0;
  logic           req_ready;
  logic           act_cmd;
  logic [AW-1:0]  act_addr;
  logic           rfm_cmd;
  logic           nrr_cmd = 1'b0;
  logic [AW-1:0]  nrr_addr = '0;
  logic           vic_valid;
  logic [AW-1:0]  vic_addr;
  logic           vic_ready = 1'b0;
  logic [4:0]     raa_cnt;
  logic           nrr_ovf;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  act_exp_t act_q[$];
  int       rfm_q[$];
  vic_exp_t vic_q[$];

  rfm_act_issuer dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .act_cmd   (act_cmd),
    .act_addr  (act_addr),
    .rfm_cmd   (rfm_cmd),
    .nrr_cmd   (nrr_cmd),
    .nrr_addr  (nrr_addr),
    .vic_valid (vic_valid),
    .vic_addr  (vic_addr),
    .vic_ready (vic_ready),
    .raa_cnt   (raa_cnt),
    .nrr_ovf   (nrr_ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint actual, input longint expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, actual, expected, cyc);
    end
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #3;
    rst       = 1'b1;
    req_valid = 1'b0;
    nrr_cmd   = 1'b0;
    vic_ready = 1'b0;
    act_q.delete();
    rfm_q.delete();
    vic_q.delete();
    @(negedge clk);
    #3;
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Hold req_valid for 20 back-to-back requests starting now; returns the
  // cycle of the 20th handshake. Address of request k is base+k.
  task automatic run_twenty(input logic [AW-1:0] base, output int n20);
    int h0;
    h0 = cyc;
    for (int k = 0; k < 20; k++) begin
      act_exp_t e;
      e.cyc  = h0 + 60 * k + 1;
      e.addr = base + AW'(k);
      e.raa  = k + 1;
      act_q.push_back(e);
    end
    n20 = h0 + 19 * 60;
    rfm_q.push_back(n20 + 60);
    req_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      wait_cyc(h0 + 60 * k);
      req_addr = base + AW'(k);
    end
  endtask

  // Monitor: sample outputs just after the falling edge and pop expectations.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        if (act_cmd) begin
          if (act_q.size() == 0) begin
            chk("unexpected_act", 1, 0);
          end else begin
            act_exp_t e;
            e = act_q.pop_front();
            chk("act_cycle", cyc, e.cyc);
            chk("act_addr", act_addr, e.addr);
            chk("act_raa", raa_cnt, e.raa);
          end
        end
        if (rfm_cmd) begin
          if (rfm_q.size() == 0) begin
            chk("unexpected_rfm", 1, 0);
          end else begin
            int ec;
            ec = rfm_q.pop_front();
            chk("rfm_cycle", cyc, ec);
            chk("rfm_raa_clear", raa_cnt, 0);
          end
        end
        if (vic_valid && vic_ready) begin
          if (vic_q.size() == 0) begin
            chk("unexpected_vic", 1, 0);
          end else begin
            vic_exp_t v;
            v = vic_q.pop_front();
            chk("vic_addr", vic_addr, v.addr);
            if (v.cyc >= 0) chk("vic_cycle", cyc, v.cyc);
          end
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int h0;
    int n20;
    int m;
    act_exp_t e;
    vic_exp_t v;

    // ---- reset state and T_RC spacing with req_valid held at addr 5
    do_reset();
    chk("rst_req_ready", req_ready, 1);
    chk("rst_act_cmd", act_cmd, 0);
    chk("rst_rfm_cmd", rfm_cmd, 0);
    chk("rst_act_addr", act_addr, 0);
    chk("rst_raa", raa_cnt, 0);
    chk("rst_vic_valid", vic_valid, 0);
    chk("rst_vic_addr", vic_addr, 0);
    chk("rst_nrr_ovf", nrr_ovf, 0);
    h0 = cyc;
    for (int k = 0; k < 3; k++) begin
      e.cyc  = h0 + 1 + 60 * k;
      e.addr = 18'd5;
      e.raa  = k + 1;
      act_q.push_back(e);
    end
    req_valid = 1'b1;
    req_addr  = 18'd5;
    wait_cyc(h0 + 30);
    chk("gap_req_ready", req_ready, 0);
    wait_cyc(h0 + 121);
    req_valid = 1'b0;
    wait_cyc(h0 + 130);

    // ---- 20 ACTs, RFM insertion and blackout
    do_reset();
    run_twenty(18'h100, n20);
    e.cyc  = n20 + 261;
    e.addr = 18'h100 + 18'd19;
    e.raa  = 1;
    act_q.push_back(e);
    wait_cyc(n20 + 59);
    chk("pre_rfm_raa", raa_cnt, 20);
    wait_cyc(n20 + 150);
    chk("busy_req_ready", req_ready, 0);
    wait_cyc(n20 + 259);
    chk("busy_end_req_ready", req_ready, 0);
    wait_cyc(n20 + 260);
    chk("post_rfm_req_ready", req_ready, 1);
    wait_cyc(n20 + 261);
    req_valid = 1'b0;
    wait_cyc(n20 + 270);

    // ---- victim sequencer
    do_reset();
`ifdef RFM_ACT_ISSUER_VICTIM_EN
    // addr 100 -> 99, 101 on consecutive cycles
    m = cyc;
    vic_ready = 1'b1;
    nrr_cmd = 1'b1; nrr_addr = 18'd100;
    v.cyc = m + 1; v.addr = 18'd99;  vic_q.push_back(v);
    v.cyc = m + 2; v.addr = 18'd101; vic_q.push_back(v);
    @(negedge clk); nrr_cmd = 1'b0;
    wait_cyc(m + 6);
    // edge rows
    m = cyc;
    nrr_cmd = 1'b1; nrr_addr = 18'd0;
    v.cyc = m + 1; v.addr = 18'd1; vic_q.push_back(v);
    @(negedge clk); nrr_cmd = 1'b0;
    wait_cyc(m + 5);
    m = cyc;
    nrr_cmd = 1'b1; nrr_addr = 18'h3FFFF;
    v.cyc = m + 1; v.addr = 18'h3FFFE; vic_q.push_back(v);
    @(negedge clk); nrr_cmd = 1'b0;
    wait_cyc(m + 5);
    // NRR in the cycle of the final handshake is accepted
    m = cyc;
    nrr_cmd = 1'b1; nrr_addr = 18'd400;
    v.cyc = m + 1; v.addr = 18'd399; vic_q.push_back(v);
    v.cyc = m + 2; v.addr = 18'd401; vic_q.push_back(v);
    @(negedge clk); nrr_cmd = 1'b0;
    wait_cyc(m + 2);
    nrr_cmd = 1'b1; nrr_addr = 18'd500;
    v.cyc = m + 3; v.addr = 18'd499; vic_q.push_back(v);
    v.cyc = m + 4; v.addr = 18'd501; vic_q.push_back(v);
    @(negedge clk); nrr_cmd = 1'b0;
    wait_cyc(m + 8);
    chk("no_ovf_on_final_hs", nrr_ovf, 0);
    // overflow while stalled; original victims unchanged
    vic_ready = 1'b0;
    nrr_cmd = 1'b1; nrr_addr = 18'd200;
    v.cyc = -1; v.addr = 18'd199; vic_q.push_back(v);
    v.cyc = -1; v.addr = 18'd201; vic_q.push_back(v);
    @(negedge clk);
    nrr_addr = 18'd300;
    @(negedge clk);
    nrr_cmd = 1'b0;
    chk("ovf_set", nrr_ovf, 1);
    chk("stall_vic_valid", vic_valid, 1);
    chk("stall_vic_addr", vic_addr, 199);
    vic_ready = 1'b1;
    repeat (5) @(negedge clk);
    chk("ovf_sticky", nrr_ovf, 1);
    vic_ready = 1'b0;
`else
    m = cyc;
    vic_ready = 1'b1;
    nrr_cmd = 1'b1; nrr_addr = 18'd100;
    @(negedge clk);
    chk("off_vic_valid", vic_valid, 0);
    chk("off_vic_addr", vic_addr, 0);
    @(negedge clk);
    chk("off_nrr_ovf", nrr_ovf, 0);
    nrr_cmd = 1'b0;
    vic_ready = 1'b0;
    wait_cyc(m + 5);
    chk("off_vic_valid_late", vic_valid, 0);
`endif

    // ---- reset during RFM blackout with a victim pending
    run_twenty(18'h2000, n20);
    wait_cyc(n20 + 100);
    req_valid = 1'b0;
`ifdef RFM_ACT_ISSUER_VICTIM_EN
    nrr_cmd = 1'b1; nrr_addr = 18'd50;
    @(negedge clk); nrr_cmd = 1'b0;
    @(negedge clk);
    chk("pending_vic_valid", vic_valid, 1);
`endif
    chk("blackout_req_ready", req_ready, 0);
    do_reset();
    chk("post_rst_req_ready", req_ready, 1);
    chk("post_rst_raa", raa_cnt, 0);
    chk("post_rst_vic_valid", vic_valid, 0);
    chk("post_rst_nrr_ovf", nrr_ovf, 0);
    vic_ready = 1'b1;
    repeat (300) @(negedge clk);
    vic_ready = 1'b0;

    chk("act_q_drained", act_q.size(), 0);
    chk("rfm_q_drained", rfm_q.size(), 0);
    chk("vic_q_drained", vic_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
